// File: rtl/counter_dump_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_dump_ctrl_pkg
//   Shared types and constants for the performance-counter dump controller.
//   counters_t     : live counter struct, 25 fields x 32 bits. Field order
//                    defines the dump index (0 = cycles).
//   CNT_NUM        : number of counter fields.
//   dump_state_t   : controller FSM states.
// ---------------------------------------------------------------------------
package counter_dump_ctrl_pkg;

    localparam int CNT_NUM = 25;
    localparam int CNT_W   = 32;
    localparam int IDX_W   = 5;

    // Index of the final word of a dump; the stream never goes past it.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CNT_NUM - 1);

    typedef struct packed {
        logic [CNT_W-1:0] cycles;
        logic [CNT_W-1:0] instret;
        logic [CNT_W-1:0] ld_cnt;
        logic [CNT_W-1:0] st_cnt;
        logic [CNT_W-1:0] br_cnt;
        logic [CNT_W-1:0] br_miss;
        logic [CNT_W-1:0] jmp_cnt;
        logic [CNT_W-1:0] icache_hit;
        logic [CNT_W-1:0] icache_miss;
        logic [CNT_W-1:0] dcache_hit;
        logic [CNT_W-1:0] dcache_miss;
        logic [CNT_W-1:0] itlb_miss;
        logic [CNT_W-1:0] dtlb_miss;
        logic [CNT_W-1:0] stall_fetch;
        logic [CNT_W-1:0] stall_decode;
        logic [CNT_W-1:0] stall_exec;
        logic [CNT_W-1:0] stall_mem;
        logic [CNT_W-1:0] stall_wb;
        logic [CNT_W-1:0] fwd_cnt;
        logic [CNT_W-1:0] flush_cnt;
        logic [CNT_W-1:0] irq_cnt;
        logic [CNT_W-1:0] exc_cnt;
        logic [CNT_W-1:0] mul_cnt;
        logic [CNT_W-1:0] div_cnt;
        logic [CNT_W-1:0] fpu_cnt;
    } counters_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_t;

endpackage

// File: rtl/dump_period_timer.sv
// ---------------------------------------------------------------------------
// dump_period_timer
//   Free-running auto-dump interval timer plus a single pending flag that
//   remembers an expiry seen while the controller was busy.
//   clk, rst     : clock, asynchronous active-high reset
//   dump_period  : interval in cycles; 0 disables the timer and pending flag
//   in_idle      : controller is in IDLE this cycle (pending gets consumed)
//   expire       : timer hits its terminal count this cycle (combinational)
//   pending      : an expiry occurred while not idle and is still unserved
// ---------------------------------------------------------------------------
module dump_period_timer
    import counter_dump_ctrl_pkg::*;
#(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] dump_period,
    input  logic                in_idle,
    output logic                expire,
    output logic                pending
);

    logic [PERIOD_W-1:0] timer_reg;
    logic [PERIOD_W-1:0] timer_next;
    logic                pending_reg;
    logic                pending_next;
    logic                enabled;

    assign enabled = (dump_period != '0);

    // ">=" rather than "==" so that shrinking dump_period below the current
    // count fires on the next edge instead of waiting for a full wrap.
    assign expire = enabled && (timer_reg >= (dump_period - 1'b1));

    always_comb begin
        timer_next   = timer_reg + 1'b1;
        pending_next = pending_reg;
        if (!enabled) begin
            timer_next   = '0;
            pending_next = 1'b0;
        end else begin
            if (expire) begin
                timer_next = '0;
            end
            // In IDLE any pending request starts a dump on this edge, so the
            // flag is always consumed there. Expiries while busy collapse
            // into one pending request.
            if (in_idle) begin
                pending_next = 1'b0;
            end else if (expire) begin
                pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg   <= '0;
            pending_reg <= 1'b0;
        end else begin
            timer_reg   <= timer_next;
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/counter_dump_ctrl.sv
// ---------------------------------------------------------------------------
// counter_dump_ctrl
//   Snapshots all performance counters in one cycle and streams them out as
//   25 32-bit words over a valid/ready interface. Dumps start on dump_req,
//   on auto-dump timer expiry, or on a timer expiry left pending while busy.
//   clk, rst      : clock, asynchronous active-high reset
//   cnt           : live counter struct
//   dump_req      : request one dump (honoured only in IDLE)
//   dump_period   : auto-dump interval in cycles, 0 = off
//   out_valid/out_ready/out_data/out_idx/out_last : word stream
//   busy          : high while streaming and in the DONE cycle
//   dump_done     : one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module counter_dump_ctrl
    import counter_dump_ctrl_pkg::*;
#(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  counters_t           cnt,
    input  logic                dump_req,
    input  logic [PERIOD_W-1:0] dump_period,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    out_data,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_last,
    output logic                busy,
    output logic                dump_done
);

    // -----------------------------------------------------------------------
    // Flatten the struct: the first declared field sits in the MSBs of the
    // packed vector and becomes index 0.
    // -----------------------------------------------------------------------
    logic [CNT_NUM*CNT_W-1:0] cnt_flat;
    logic [CNT_W-1:0]         cnt_arr [CNT_NUM];

    assign cnt_flat = cnt;

    generate
        for (genvar gi = 0; gi < CNT_NUM; gi++) begin : g_flat
            assign cnt_arr[gi] = cnt_flat[(CNT_NUM-1-gi)*CNT_W +: CNT_W];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    dump_state_t         state_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_plus1;
    logic [CNT_W-1:0]    out_data_reg;
    logic                out_valid_reg;
    logic                out_last_reg;
    logic                busy_reg;
    logic                dump_done_reg;
    logic [CNT_W-1:0]    snap_reg [CNT_NUM];

    logic                in_idle;
    logic                timer_expire;
    logic                timer_pending;
    logic                start;

    assign in_idle   = (state_reg == IDLE);
    assign idx_plus1 = idx_reg + 1'b1;

    // Any combination of trigger sources in IDLE yields exactly one dump.
    assign start = in_idle && (dump_req || timer_expire || timer_pending);

    dump_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .dump_period (dump_period),
        .in_idle     (in_idle),
        .expire      (timer_expire),
        .pending     (timer_pending)
    );

    // -----------------------------------------------------------------------
    // Snapshot array: every field is captured on the trigger edge, so all
    // words of one dump are coherent regardless of cnt activity afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CNT_NUM; i++) begin
                snap_reg[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < CNT_NUM; i++) begin
                snap_reg[i] <= cnt_arr[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            dump_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= STREAM;
                        idx_reg       <= '0;
                        // Word 0 comes straight from the live input: the
                        // snapshot register is being written on this edge.
                        out_data_reg  <= cnt_arr[0];
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (LAST_IDX == '0);
                        busy_reg      <= 1'b1;
                    end
                end

                STREAM: begin
                    // out_valid is always high here, so ready alone means
                    // a handshake. Without ready everything holds.
                    if (out_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            dump_done_reg <= 1'b1;
                        end else begin
                            idx_reg       <= idx_plus1;
                            out_data_reg  <= snap_reg[idx_plus1];
                            out_last_reg  <= (idx_plus1 == LAST_IDX);
                        end
                    end
                end

                DONE: begin
                    state_reg     <= IDLE;
                    busy_reg      <= 1'b0;
                    dump_done_reg <= 1'b0;
                end

                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                    dump_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = idx_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;
    assign dump_done = dump_done_reg;

endmodule
